// File: rtl/led_pattern_engine_if.sv
// Control/status bundle between the PIO control register and the LED pattern engine.
interface led_pattern_engine_if #(
    parameter int unsigned LED_W = 8
);
    logic [1:0]       ctrl_in;
    logic [LED_W-1:0] led;
    logic             busy;
    logic             cycle_done;

    modport master (output ctrl_in, input led, input busy, input cycle_done);
    modport slave  (input ctrl_in, output led, output busy, output cycle_done);
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine: bounces a single lit LED back and forth, or runs a binary
// counter, advancing once every TICK_DIV clocks while the run bit is set.
module led_pattern_engine #(
    parameter int unsigned LED_W    = 8,
    parameter int unsigned TICK_DIV = 12500000
) (
    input logic                  clk,
    input logic                  reset,
    led_pattern_engine_if.slave  bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_R = 2'd2,
        COUNT   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             busy_q, busy_d;
    logic             cycle_done_q, cycle_done_d;
    logic             step;

    assign step = (state_q != IDLE) && (cnt_q == CNT_MAX);

    // Next-state: stop beats mode change, mode change beats step.
    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        cnt_d        = cnt_q;
        cycle_done_d = 1'b0;
        ctrl_d       = bus.ctrl_in;

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (ctrl_q[0]) begin
                state_d = ctrl_q[1] ? COUNT : SHIFT_L;
                led_d   = ctrl_q[1] ? '0 : LED_W'(1);
            end
        end else if (!ctrl_q[0]) begin
            state_d = IDLE;
            led_d   = '0;
            cnt_d   = '0;
        end else if (ctrl_q[1] != (state_q == COUNT)) begin
            state_d = ctrl_q[1] ? COUNT : SHIFT_L;
            led_d   = ctrl_q[1] ? '0 : LED_W'(1);
            cnt_d   = '0;
        end else begin
            cnt_d = step ? '0 : cnt_q + CNT_W'(1);
            if (step) begin
                case (state_q)
                    SHIFT_L: begin
                        if (led_q[LED_W-1]) begin
                            state_d = SHIFT_R;
                            led_d   = led_q >> 1;
                        end else begin
                            led_d   = led_q << 1;
                        end
                    end
                    SHIFT_R: begin
                        if (led_q[0]) begin
                            state_d = SHIFT_L;
                            led_d   = led_q << 1;
                        end else begin
                            led_d        = led_q >> 1;
                            // Landing back on the LSB closes one bounce period.
                            cycle_done_d = led_q[1];
                        end
                    end
                    COUNT: begin
                        led_d        = led_q + LED_W'(1);
                        cycle_done_d = &led_q;
                    end
                    default: ;
                endcase
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ctrl_q       <= '0;
            cnt_q        <= '0;
            led_q        <= '0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            cnt_q        <= cnt_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.busy       = busy_q;
    assign bus.cycle_done = cycle_done_q;

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 Parameter LED_W, default 8: LED output width; legal range 2..32.
REQ-002 Parameter TICK_DIV, default 12500000: clk cycles per pattern step (4 Hz at 50 MHz); legal minimum 2.
REQ-003 clk  input  1: single clock; all logic SHALL be rising-edge clocked.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 ctrl_in  input  2: control word from the PIO control register; bit0 = run, bit1 = mode (0 bounce, 1 count).
REQ-006 led  output  LED_W: LED drive, registered.
REQ-007 busy  output  1: high when the state is not IDLE, registered.
REQ-008 cycle_done  output  1: one-cycle pulse at pattern period completion, registered.

Function
REQ-009 ctrl_in SHALL be registered once (ctrl_q); all decisions SHALL use ctrl_q only.
REQ-010 States: IDLE, SHIFT_L, SHIFT_R, COUNT.
REQ-011 Prescaler cnt: counts 0..TICK_DIV-1 and wraps to 0; held at 0 in IDLE and on any restart.
REQ-012 step strobe = (state != IDLE) and (cnt == TICK_DIV-1); led/state advance only on step, except for restart or stop.
REQ-013 IDLE, ctrl_q[0]=1: with ctrl_q[1]=0, go to SHIFT_L with led=1; with ctrl_q[1]=1, go to COUNT with led=0; cnt=0.
REQ-014 Latency: ctrl_in change at edge N -> ctrl_q at edge N+1 -> state/led update at edge N+2.
REQ-015 SHIFT_L on step: if led[LED_W-1]=1, go to SHIFT_R with led = led>>1; otherwise led = led<<1.
REQ-016 SHIFT_R on step: if led[0]=1, stay in SHIFT_R? No: go to SHIFT_L with led = led<<1; otherwise led = led>>1.
REQ-017 In SHIFT_R, cycle_done SHALL pulse on the edge where led becomes 1 (bounce returns to LSB).
REQ-018 COUNT on step: led = led + 1 modulo 2^LED_W; cycle_done SHALL pulse on the edge where led wraps from all-ones to 0.
REQ-019 In bounce modes, led SHALL be one-hot at all times.
REQ-020 Stop: ctrl_q[0]=0 in any non-IDLE state -> next edge state=IDLE, led=0, cnt=0, cycle_done=0; takes priority over step.
REQ-021 Mode change while running: ctrl_q[1] differs from the current mode family -> next edge restart as in REQ-013 for the new mode; takes priority over step.
REQ-022 cycle_done SHALL be 0 on every edge without a qualifying event; never high for more than 1 cycle.
REQ-023 busy SHALL equal (state != IDLE) as registered, aligned with led.
REQ-024 Counter widths SHALL be sized by clog2(TICK_DIV); no truncation or overflow beyond TICK_DIV-1.

Reset
REQ-025 reset=1 at an edge SHALL force state=IDLE, ctrl_q=0, cnt=0, led=0, busy=0, cycle_done=0, overriding all other events.
REQ-026 Reset asserted mid-pattern SHALL abort the pattern; after deassertion with ctrl_in held at run, restart follows REQ-014 timing from ctrl_q refill.
REQ-027 The block SHALL have no asynchronous reset path.

Verification (LED_W=4, TICK_DIV=4)
REQ-028 Bounce: ctrl_in=01 at edge 0. Required: led=0001/busy=1 at edge 2, then led 0010@6, 0100@10, 1000@14, 0100@18, 0010@22, 0001@26 with cycle_done=1 only in the cycle after edge 26, then 0010@30.
REQ-029 Count: ctrl_in=11 at edge 0. Required: led=0000 at edge 2, increment every 4 edges, 1111@62, 0000@66 with a single-cycle cycle_done pulse.
REQ-030 Stop: in COUNT with led=0101, drive ctrl_in=10. Required: 2 edges later led=0000, busy=0; led stays 0 with no cycle_done.
REQ-031 Mode switch: in SHIFT_L with led=0100 and cnt=2, drive ctrl_in=11. Required: led=0000 in COUNT 2 edges later; first increment exactly 4 edges after that.
REQ-032 Reset priority: reset=1 on the same edge as a step in SHIFT_R. Required: all outputs 0; with ctrl_in=01 held, led=0001 two edges after reset release.
REQ-033 Glitch: a 1-cycle ctrl_in=01 pulse from IDLE. Required: enters SHIFT_L (led=0001) at edge 2 and returns to IDLE at edge 3.
